vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter.sv | 150 +++++++++++++++
 tb/tb_vram_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Single-port screen-RAM arbiter: video fetches (pixel + attribute) take priority over
// CPU accesses; every RAM access is a registered address cycle followed by a data cycle.
module vram_arbiter #(
   parameter int unsigned ADDR_W = 13,
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_pix_addr,
   input  logic [ADDR_W-1:0] vid_attr_addr,
   output logic [DATA_W-1:0] vid_pix_data,
   output logic [DATA_W-1:0] vid_attr_data,
   output logic              vid_valid,
   output logic              vid_overrun,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ack,
   output logic              cpu_wait,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   typedef enum logic [2:0] {
      IDLE,
      VPIX,
      VATTR,
      VCAP,
      CADDR,
      CDATA
   } state_t;

   state_t            state;
   state_t            state_nxt;

   logic              vid_pend;
   logic              vid_accept;
   logic [ADDR_W-1:0] pix_addr_q;
   logic [ADDR_W-1:0] attr_addr_q;
   logic [ADDR_W-1:0] vpix_addr;
   logic [DATA_W-1:0] pix_q;
   logic [DATA_W-1:0] cpu_rdata_q;
   logic              cpu_we_q;

   // A request is lost if one is already queued or the fetch slots are being used.
   assign vid_accept = vid_req && !vid_pend && (state != VPIX) && (state != VATTR);
   // Fresh request in IDLE goes straight to RAM; a queued one uses the latched address.
   assign vpix_addr  = vid_pend ? pix_addr_q : vid_pix_addr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (vid_req || vid_pend) begin
               state_nxt = VPIX;
            end else if (cpu_req) begin
               state_nxt = CADDR;
            end
         end
         VPIX:    state_nxt = VATTR;
         VATTR:   state_nxt = VCAP;
         VCAP:    state_nxt = IDLE;
         CADDR:   state_nxt = CDATA;
         CDATA:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      cpu_ack   = 1'b0;
      cpu_rdata = cpu_rdata_q;
      if (state == CDATA) begin
         cpu_ack = 1'b1;
         if (!cpu_we_q) begin
            cpu_rdata = ram_rdata;
         end
      end
      cpu_wait = cpu_req && !cpu_ack;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vid_pend      <= 1'b0;
         vid_overrun   <= 1'b0;
         vid_valid     <= 1'b0;
         vid_pix_data  <= '0;
         vid_attr_data <= '0;
         pix_addr_q    <= '0;
         attr_addr_q   <= '0;
         pix_q         <= '0;
         cpu_rdata_q   <= '0;
         cpu_we_q      <= 1'b0;
         ram_addr      <= '0;
         ram_we        <= 1'b0;
         ram_wdata     <= '0;
      end else begin
         if (state == IDLE && state_nxt == VPIX) begin
            vid_pend <= 1'b0;
         end else if (vid_accept) begin
            vid_pend <= 1'b1;
         end
         if (vid_req && !vid_accept) begin
            vid_overrun <= 1'b1;
         end
         if (vid_accept) begin
            pix_addr_q  <= vid_pix_addr;
            attr_addr_q <= vid_attr_addr;
         end

         ram_we <= 1'b0;
         case (state_nxt)
            VPIX:  ram_addr <= vpix_addr;
            VATTR: ram_addr <= attr_addr_q;
            CADDR: begin
               ram_addr  <= cpu_addr;
               ram_we    <= cpu_we;
               ram_wdata <= cpu_wdata;
               cpu_we_q  <= cpu_we;
            end
            default: ;
         endcase

         if (state == VATTR) begin
            pix_q <= ram_rdata;
         end
         vid_valid <= (state == VCAP);
         if (state == VCAP) begin
            vid_attr_data <= ram_rdata;
            vid_pix_data  <= pix_q;
         end
         if (state == CDATA && !cpu_we_q) begin
            cpu_rdata_q <= ram_rdata;
         end
      end
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: a table of single transactions followed by
// hand-written sequences for contention, overrun and reset corner cases.
module tb_vram_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        vid_req;
   logic [12:0] vid_pix_addr;
   logic [12:0] vid_attr_addr;
   logic [7:0]  vid_pix_data;
   logic [7:0]  vid_attr_data;
   logic        vid_valid;
   logic        vid_overrun;
   logic        cpu_req;
   logic        cpu_we;
   logic [12:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic [7:0]  cpu_rdata;
   logic        cpu_ack;
   logic        cpu_wait;
   logic [12:0] ram_addr;
   logic        ram_we;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata;

   logic [7:0]  mem [0:8191];

   int checks = 0;
   int errors = 0;

   typedef struct {
      int          kind;   // 0 video, 1 cpu read, 2 cpu write
      logic [12:0] a0;
      logic [12:0] a1;
      logic [7:0]  wd;
      logic [7:0]  e0;     // video: pixel; cpu: cpu_rdata at ack
      logic [7:0]  e1;     // video: attribute
   } vec_t;

   vec_t vecs [8];

   vram_arbiter #(.ADDR_W(13), .DATA_W(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .vid_req      (vid_req),
      .vid_pix_addr (vid_pix_addr),
      .vid_attr_addr(vid_attr_addr),
      .vid_pix_data (vid_pix_data),
      .vid_attr_data(vid_attr_data),
      .vid_valid    (vid_valid),
      .vid_overrun  (vid_overrun),
      .cpu_req      (cpu_req),
      .cpu_we       (cpu_we),
      .cpu_addr     (cpu_addr),
      .cpu_wdata    (cpu_wdata),
      .cpu_rdata    (cpu_rdata),
      .cpu_ack      (cpu_ack),
      .cpu_wait     (cpu_wait),
      .ram_addr     (ram_addr),
      .ram_we       (ram_we),
      .ram_wdata    (ram_wdata),
      .ram_rdata    (ram_rdata)
   );

   always #5 clk = ~clk;

   // Synchronous single-port RAM, read latency 1.
   always @(posedge clk) begin
      if (ram_we) begin
         mem[ram_addr] <= ram_wdata;
      end
      ram_rdata <= mem[ram_addr];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic vid_txn(input logic [12:0] pix, input logic [12:0] attr,
                          input logic [7:0] epix, input logic [7:0] eattr, input int elat);
      int valid_at;
      int vcnt;
      valid_at = 0;
      vcnt     = 0;
      vid_req       = 1'b1;
      vid_pix_addr  = pix;
      vid_attr_addr = attr;
      for (int n = 1; n <= 12; n++) begin
         tick();
         if (n == 1) vid_req = 1'b0;
         if (n == elat - 3) check("vid_ram_addr_pix", ram_addr, pix);
         if (n == elat - 2) check("vid_ram_addr_attr", ram_addr, attr);
         if (vid_valid) begin
            vcnt++;
            if (valid_at == 0) valid_at = n;
         end
      end
      check("vid_latency", valid_at, elat);
      check("vid_valid_count", vcnt, 1);
      check("vid_pix_data", vid_pix_data, epix);
      check("vid_attr_data", vid_attr_data, eattr);
      check("vid_no_overrun", vid_overrun, 1'b0);
   endtask

   task automatic cpu_txn(input logic we, input logic [12:0] addr, input logic [7:0] wdata,
                          input logic [7:0] erdata);
      int ack_at;
      int ack_cnt;
      int wait_cnt;
      int we_cnt;
      ack_at   = 0;
      ack_cnt  = 0;
      wait_cnt = 0;
      we_cnt   = 0;
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = addr;
      cpu_wdata = wdata;
      #1;
      if (cpu_wait) wait_cnt++;
      for (int n = 1; n <= 10; n++) begin
         tick();
         if (ack_at != 0) cpu_req = 1'b0;
         #1;
         if (cpu_wait) wait_cnt++;
         if (ram_we) begin
            we_cnt++;
            check("cpu_ram_addr_we", ram_addr, addr);
            check("cpu_ram_wdata", ram_wdata, wdata);
         end
         if (cpu_ack) begin
            ack_cnt++;
            if (ack_at == 0) ack_at = n;
            check("cpu_rdata_at_ack", cpu_rdata, erdata);
         end
      end
      cpu_req = 1'b0;
      check("cpu_ack_cycle", ack_at, 2);
      check("cpu_ack_count", ack_cnt, 1);
      check("cpu_wait_cycles", wait_cnt, 2);
      check("cpu_ram_we_cycles", we_cnt, we ? 1 : 0);
   endtask

   initial begin
      int va;
      int va2;
      int aa;
      int vcnt;

      for (int i = 0; i < 8192; i++) mem[i] <= 8'h00;
      mem[13'h0123] <= 8'hAA;
      mem[13'h1804] <= 8'h47;
      mem[13'h0500] <= 8'h5C;
      mem[13'h0000] <= 8'h11;
      mem[13'h1FFF] <= 8'hE7;
      mem[13'h0200] <= 8'h33;

      vecs[0] = '{0, 13'h0123, 13'h1804, 8'h00, 8'hAA, 8'h47};
      vecs[1] = '{1, 13'h0500, 13'h0000, 8'h00, 8'h5C, 8'h00};
      vecs[2] = '{2, 13'h1800, 13'h0000, 8'h3F, 8'h5C, 8'h00};
      vecs[3] = '{1, 13'h1800, 13'h0000, 8'h00, 8'h3F, 8'h00};
      vecs[4] = '{0, 13'h0000, 13'h1FFF, 8'h00, 8'h11, 8'hE7};
      vecs[5] = '{2, 13'h0123, 13'h0000, 8'h96, 8'h3F, 8'h00};
      vecs[6] = '{0, 13'h0123, 13'h1800, 8'h00, 8'h96, 8'h3F};
      vecs[7] = '{1, 13'h1FFF, 13'h0000, 8'h00, 8'hE7, 8'h00};

      reset = 1'b1;
      vid_req = 1'b0; vid_pix_addr = '0; vid_attr_addr = '0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      tick();
      tick();
      check("rst_ram_addr", ram_addr, 13'h0);
      check("rst_ram_we", ram_we, 1'b0);
      check("rst_ram_wdata", ram_wdata, 8'h0);
      check("rst_vid_valid", vid_valid, 1'b0);
      check("rst_vid_overrun", vid_overrun, 1'b0);
      check("rst_vid_pix", vid_pix_data, 8'h0);
      check("rst_vid_attr", vid_attr_data, 8'h0);
      check("rst_cpu_ack", cpu_ack, 1'b0);
      check("rst_cpu_rdata", cpu_rdata, 8'h0);
      check("rst_cpu_wait", cpu_wait, 1'b0);
      reset = 1'b0;
      tick();

      foreach (vecs[i]) begin
         if (vecs[i].kind == 0) begin
            vid_txn(vecs[i].a0, vecs[i].a1, vecs[i].e0, vecs[i].e1, 4);
         end else begin
            cpu_txn(vecs[i].kind == 2, vecs[i].a0, vecs[i].wd, vecs[i].e0);
         end
         tick();
         tick();
      end

      // Video and CPU requested in the same IDLE cycle: video first.
      va = 0; aa = 0;
      vid_req = 1'b1; vid_pix_addr = 13'h0500; vid_attr_addr = 13'h0000;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h1804;
      for (int n = 1; n <= 12; n++) begin
         tick();
         if (n == 1) vid_req = 1'b0;
         if (aa != 0) cpu_req = 1'b0;
         if (vid_valid && va == 0) va = n;
         if (cpu_ack && aa == 0) begin
            aa = n;
            check("simul_cpu_rdata", cpu_rdata, 8'h47);
         end
      end
      cpu_req = 1'b0;
      check("simul_vid_latency", va, 4);
      check("simul_cpu_ack_cycle", aa, 6);
      check("simul_vid_pix", vid_pix_data, 8'h5C);
      check("simul_vid_attr", vid_attr_data, 8'h11);
      tick();

      // Video request during CADDR of a CPU write: queued, CPU completes first.
      va = 0; aa = 0;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0100; cpu_wdata = 8'h5A;
      tick();
      vid_req = 1'b1; vid_pix_addr = 13'h0100; vid_attr_addr = 13'h1804;
      for (int n = 2; n <= 14; n++) begin
         tick();
         if (n == 2) vid_req = 1'b0;
         if (aa != 0) cpu_req = 1'b0;
         if (vid_valid && va == 0) va = n;
         if (cpu_ack && aa == 0) aa = n;
      end
      cpu_req = 1'b0;
      check("busy_cpu_ack_cycle", aa, 2);
      check("busy_vid_valid_cycle", va, 7);
      check("busy_vid_pix", vid_pix_data, 8'h5A);
      check("busy_vid_attr", vid_attr_data, 8'h47);
      check("busy_no_overrun", vid_overrun, 1'b0);
      tick();

      // Second request during VCAP is queued, not an overrun.
      va = 0; va2 = 0; vcnt = 0;
      vid_req = 1'b1; vid_pix_addr = 13'h0000; vid_attr_addr = 13'h1FFF;
      for (int n = 1; n <= 14; n++) begin
         tick();
         if (n == 1) vid_req = 1'b0;
         if (n == 4) vid_req = 1'b0;
         if (vid_valid) begin
            vcnt++;
            if (va == 0) begin
               va = n;
               check("vcap_first_pix", vid_pix_data, 8'h11);
               check("vcap_first_attr", vid_attr_data, 8'hE7);
            end else if (va2 == 0) begin
               va2 = n;
               check("vcap_second_pix", vid_pix_data, 8'hE7);
               check("vcap_second_attr", vid_attr_data, 8'h96);
            end
         end
         if (n == 3) begin
            vid_req = 1'b1; vid_pix_addr = 13'h1FFF; vid_attr_addr = 13'h0123;
         end
      end
      check("vcap_first_cycle", va, 4);
      check("vcap_second_cycle", va2, 8);
      check("vcap_valid_count", vcnt, 2);
      check("vcap_no_overrun", vid_overrun, 1'b0);
      tick();

      // Second request one cycle after the first is lost and flagged.
      va = 0; vcnt = 0;
      vid_req = 1'b1; vid_pix_addr = 13'h0123; vid_attr_addr = 13'h1804;
      for (int n = 1; n <= 12; n++) begin
         tick();
         if (n == 1) begin
            check("ovr_not_yet", vid_overrun, 1'b0);
            vid_pix_addr = 13'h0500; vid_attr_addr = 13'h0000;
         end
         if (n == 2) begin
            vid_req = 1'b0;
            check("ovr_set", vid_overrun, 1'b1);
         end
         if (vid_valid) begin
            vcnt++;
            if (va == 0) va = n;
         end
      end
      check("ovr_valid_count", vcnt, 1);
      check("ovr_valid_cycle", va, 4);
      check("ovr_pix", vid_pix_data, 8'h96);
      check("ovr_attr", vid_attr_data, 8'h47);
      for (int n = 0; n < 5; n++) tick();
      check("ovr_sticky", vid_overrun, 1'b1);

      // Reset during CADDR of a write aborts it.
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0200; cpu_wdata = 8'h77;
      tick();
      check("abort_caddr_we", ram_we, 1'b1);
      check("abort_caddr_addr", ram_addr, 13'h0200);
      reset = 1'b1;
      cpu_req = 1'b0;
      #1;
      check("abort_we_drop", ram_we, 1'b0);
      check("abort_ram_addr", ram_addr, 13'h0);
      check("abort_ram_wdata", ram_wdata, 8'h0);
      check("abort_cpu_ack", cpu_ack, 1'b0);
      check("abort_overrun_clr", vid_overrun, 1'b0);
      check("abort_vid_pix", vid_pix_data, 8'h0);
      check("abort_vid_attr", vid_attr_data, 8'h0);
      check("abort_cpu_rdata", cpu_rdata, 8'h0);
      tick();
      tick();
      check("abort_no_ack", cpu_ack, 1'b0);
      check("abort_no_valid", vid_valid, 1'b0);
      reset = 1'b0;
      cpu_txn(1'b0, 13'h0200, 8'h00, 8'h33);
      tick();
      cpu_txn(1'b1, 13'h0200, 8'h77, 8'h33);
      tick();
      cpu_txn(1'b0, 13'h0200, 8'h00, 8'h77);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
